inst_issue_queue: RTL and testbench
===================================

Name: inst_issue_queue

Overview:
Circular instruction buffer between fetch and the dual-issue decode stage. Fetch pushes up to two {pc, inst} entries per cycle. The queue presents the two oldest entries as pipe-a and pipe-b candidates. Each cycle, decode pops 0, 1 or 2 of them: 0 on stall, 1 when the second issue slot is refused, 2 when both issue. The queue clears on flush (branch mispredict, exception, eret).

Parameters:
DEPTH, 8, number of entries; power of two, minimum 4
ENTRY_WIDTH, 64, entry payload width ({pc[31:0], inst[31:0]})

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  synchronous clear of all entries; same priority as rst, excluding reset values of nothing
push_num  input  2  entries offered by fetch this cycle (0,1,2; 3 treated as 2)
push_data0  input  ENTRY_WIDTH  older pushed entry
push_data1  input  ENTRY_WIDTH  younger pushed entry (used only when push_num>=2)
push_ready  output  1  queue has at least 2 free slots
pop_num  input  2  entries consumed by decode this cycle (0,1,2; 3 treated as 2)
out_valid_a  output  1  oldest entry present
out_data_a  output  ENTRY_WIDTH  oldest entry
out_valid_b  output  1  second-oldest entry present
out_data_b  output  ENTRY_WIDTH  second-oldest entry
count  output  log2(DEPTH)+1  current occupancy

Behaviour:
- State: storage array[DEPTH], head pointer and tail pointer (log2(DEPTH) bits each, wrap naturally), count register.
- Reset (rst=1 at edge): head=tail=0, count=0. Array contents are don't-care.
  - Resulting outputs: out_valid_a=out_valid_b=0, out_data_a=out_data_b=0, push_ready=1, count=0.
- Outputs are combinational from registers only; there is no input-to-output path.
  - out_valid_a = (count>=1); out_valid_b = (count>=2).
  - out_data_a = array[head] when out_valid_a, else 0.
  - out_data_b = array[head+1 mod DEPTH] when out_valid_b, else 0.
  - push_ready = (DEPTH - count >= 2). A single free slot still gives push_ready=0.
- Push acceptance: push_acc = push_ready ? min(push_num,2) : 0.
  - Offers made while push_ready=0 are ignored; fetch must hold and re-offer.
  - Accepted data is written at tail, then tail+1 (data0 first), mod DEPTH; tail advances by push_acc.
- Pop: pop_eff = min(pop_num, 2, count); head advances by pop_eff mod DEPTH.
  - Over-pop is clamped, not an error. pop_num=2 with count=1 removes exactly 1.
- Simultaneous push and pop in one cycle:
  - The pop acts on pre-edge contents.
  - push_ready is evaluated on pre-edge count; slots freed by the same-cycle pop do not count.
  - count' = count + push_acc - pop_eff.
- Latency: an entry pushed at edge t is visible on out_* in the cycle after edge t. There is no same-cycle bypass.
- Ordering: strict FIFO across pointer wrap-around.
- Flush (flush=1 at edge):
  - head=tail=0, count=0; pushes and pops presented in the same cycle are discarded.
  - Next cycle: out_valid_a/b=0, push_ready=1.
- rst and flush may coincide; the result is identical to reset.
- count never exceeds DEPTH, and never underflows because of the clamping rules above.

Test Plan:
1. Reset, then push_num=2 (0x00001000_AAAA0000, 0x00001004_BBBB0000), pop_num=0 -> next cycle out_valid_a=b=1, out_data_a=0x00001000_AAAA0000, out_data_b=0x00001004_BBBB0000, count=2, push_ready=1.
2. DEPTH=8: four consecutive push_num=2, pop_num=0 -> count 2,4,6,8. push_ready=0 at count=8. A fifth push_num=2 -> ignored, count stays 8, head entry unchanged.
3. Wrap-around: fill to 8 with PCs 0x0..0x1C. Repeat {pop 2, push 2 new PCs 0x20..} eight times, then drain 2 per cycle -> out_data_a PCs strictly increasing by 8 per pop, no loss or duplication across the pointer wrap.
4. count=7 (push_ready=0) with pop_num=2 and push_num=2 in the same cycle -> push ignored, count=5. Next cycle push_ready=1 and push_num=2 is accepted, count=7.
5. count=1, pop_num=2 -> next cycle count=0, out_valid_a=0, out_valid_b=0, out_data_a=out_data_b=0.
6. count=4, flush=1 together with push_num=2 and pop_num=1 -> next cycle count=0, out_valid_a=0, push_ready=1. A following push_num=1 appears as out_data_a one cycle later.

Source files
------------

// File: rtl/inst_issue_queue.sv
// Dual-issue instruction queue between fetch and decode: up to two pushes and
// two pops per cycle, presenting the two oldest entries as pipe-a/pipe-b candidates.
module inst_issue_queue #(
  parameter int DEPTH       = 8,
  parameter int ENTRY_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               push_num,
  input  logic [ENTRY_WIDTH-1:0]   push_data0,
  input  logic [ENTRY_WIDTH-1:0]   push_data1,
  output logic                     push_ready,
  input  logic [1:0]               pop_num,
  output logic                     out_valid_a,
  output logic [ENTRY_WIDTH-1:0]   out_data_a,
  output logic                     out_valid_b,
  output logic [ENTRY_WIDTH-1:0]   out_data_b,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic [ENTRY_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [PW-1:0]          head_nxt, tail_nxt;
  logic [CW-1:0]          count_q, count_d;
  logic [1:0]             push_req, pop_req, push_acc, pop_eff;
  logic                   clear;

  assign clear    = rst | flush;
  assign push_req = push_num[1] ? 2'd2 : push_num;
  assign pop_req  = pop_num[1]  ? 2'd2 : pop_num;

  // Ready looks only at the pre-edge count, so same-cycle pops never free room.
  assign push_ready = (count_q <= READY_MAX);
  assign push_acc   = push_ready ? push_req : 2'd0;
  assign pop_eff    = (count_q >= CW'(pop_req)) ? pop_req : count_q[1:0];

  assign head_nxt = head_q + PW'(1);
  assign tail_nxt = tail_q + PW'(1);

  always_comb begin
    head_d  = head_q + PW'(pop_eff);
    tail_d  = tail_q + PW'(push_acc);
    count_d = count_q + CW'(push_acc) - CW'(pop_eff);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (push_acc != 2'd0) mem_q[tail_q]   <= push_data0;
      if (push_acc == 2'd2) mem_q[tail_nxt] <= push_data1;
    end
  end

  assign out_valid_a = (count_q != '0);
  assign out_valid_b = (count_q >= CW'(2));
  assign out_data_a  = out_valid_a ? mem_q[head_q]   : '0;
  assign out_data_b  = out_valid_b ? mem_q[head_nxt] : '0;
  assign count       = count_q;

endmodule

// File: tb/tb_inst_issue_queue.sv
// Self-checking bench for inst_issue_queue: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_inst_issue_queue;

  localparam int DEPTH = 8;
  localparam int EW    = 64;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic [1:0]    push_num, pop_num;
  logic [EW-1:0] push_data0, push_data1;
  logic          push_ready, out_valid_a, out_valid_b;
  logic [EW-1:0] out_data_a, out_data_b;
  logic [3:0]    count;

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] model[$];

  always #5 clk = ~clk;

  inst_issue_queue #(.DEPTH(DEPTH), .ENTRY_WIDTH(EW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_num(push_num), .push_data0(push_data0), .push_data1(push_data1),
    .push_ready(push_ready), .pop_num(pop_num),
    .out_valid_a(out_valid_a), .out_data_a(out_data_a),
    .out_valid_b(out_valid_b), .out_data_b(out_data_b),
    .count(count)
  );

  task automatic set_in(input logic r, input logic fl, input logic [1:0] pn,
                        input logic [EW-1:0] d0, input logic [EW-1:0] d1,
                        input logic [1:0] pp);
    rst = r; flush = fl; push_num = pn; push_data0 = d0; push_data1 = d1; pop_num = pp;
  endtask

  // Advance one clock and apply the queue rules to the reference model.
  task automatic tick();
    int sz, acc, pe;
    @(posedge clk);
    sz = model.size();
    if (rst || flush) begin
      model.delete();
    end else begin
      acc = ((DEPTH - sz) >= 2) ? ((push_num == 2'd3) ? 2 : int'(push_num)) : 0;
      pe  = (pop_num == 2'd3) ? 2 : int'(pop_num);
      if (pe > sz) pe = sz;
      for (int i = 0; i < pe; i++) void'(model.pop_front());
      if (acc >= 1) model.push_back(push_data0);
      if (acc == 2) model.push_back(push_data1);
    end
    $display("txn t=%0t rst=%0b flush=%0b push=%0d pop=%0d d0=%h model_count=%0d",
             $time, rst, flush, push_num, pop_num, push_data0, model.size());
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_in(1'b1, 1'b0, 2'd0, '0, '0, 2'd0);
    tick();
    set_in(1'b0, 1'b0, 2'd0, '0, '0, 2'd0);
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (out_valid_a !== 1'b0) begin failures++; $display("FAIL reset_va got=%0b exp=0", out_valid_a); end
    if (out_valid_b !== 1'b0) begin failures++; $display("FAIL reset_vb got=%0b exp=0", out_valid_b); end
    if (out_data_a !== '0) begin failures++; $display("FAIL reset_da got=%h exp=0", out_data_a); end
    if (out_data_b !== '0) begin failures++; $display("FAIL reset_db got=%h exp=0", out_data_b); end
    if (push_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", push_ready); end
    if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
  endtask

  task automatic test_basic();
    do_reset();
    set_in(1'b0, 1'b0, 2'd2, 64'h00001000_AAAA0000, 64'h00001004_BBBB0000, 2'd0);
    tick();
    set_in(1'b0, 1'b0, 2'd0, '0, '0, 2'd0);
    checks += 6;
    if (out_valid_a !== 1'b1) begin failures++; $display("FAIL basic_va got=%0b exp=1", out_valid_a); end
    if (out_valid_b !== 1'b1) begin failures++; $display("FAIL basic_vb got=%0b exp=1", out_valid_b); end
    if (out_data_a !== 64'h00001000_AAAA0000) begin failures++; $display("FAIL basic_da got=%h exp=00001000aaaa0000", out_data_a); end
    if (out_data_b !== 64'h00001004_BBBB0000) begin failures++; $display("FAIL basic_db got=%h exp=00001004bbbb0000", out_data_b); end
    if (count !== 4'd2) begin failures++; $display("FAIL basic_count got=%0d exp=2", count); end
    if (push_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%0b exp=1", push_ready); end
  endtask

  task automatic test_fill();
    logic [EW-1:0] first;
    do_reset();
    first = {32'h0, $urandom};
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 1'b0, 2'd2, (k == 0) ? first : {32'(8 * k), $urandom},
             {32'(8 * k + 4), $urandom}, 2'd0);
      tick();
      checks += 2;
      if (count !== 4'(2 * (k + 1))) begin failures++; $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, count, 2 * (k + 1)); end
      if (push_ready !== (k < 3)) begin failures++; $display("FAIL fill_ready k=%0d got=%0b exp=%0b", k, push_ready, k < 3); end
    end
    set_in(1'b0, 1'b0, 2'd2, 64'hDEAD, 64'hBEEF, 2'd0);
    tick();
    set_in(1'b0, 1'b0, 2'd0, '0, '0, 2'd0);
    checks += 2;
    if (count !== 4'd8) begin failures++; $display("FAIL full_push_count got=%0d exp=8", count); end
    if (out_data_a !== first) begin failures++; $display("FAIL full_push_head got=%h exp=%h", out_data_a, first); end
  endtask

  task automatic test_wrap();
    logic [31:0] next_pc, exp_pc;
    int guard;
    do_reset();
    next_pc = 0;
    exp_pc  = 0;
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 1'b0, 2'd2, {next_pc, $urandom}, {next_pc + 32'd4, $urandom}, 2'd0);
      tick();
      next_pc += 8;
    end
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (out_data_a[63:32] !== exp_pc) begin failures++; $display("FAIL wrap_pc r=%0d got=%h exp=%h", r, out_data_a[63:32], exp_pc); end
      set_in(1'b0, 1'b0, 2'd0, '0, '0, 2'd2);
      tick();
      exp_pc += 8;
      set_in(1'b0, 1'b0, 2'd2, {next_pc, $urandom}, {next_pc + 32'd4, $urandom}, 2'd0);
      tick();
      next_pc += 8;
    end
    guard = 0;
    while (count != 4'd0 && guard < 10) begin
      checks++;
      if (out_data_a[63:32] !== exp_pc) begin failures++; $display("FAIL drain_pc got=%h exp=%h", out_data_a[63:32], exp_pc); end
      set_in(1'b0, 1'b0, 2'd0, '0, '0, 2'd2);
      tick();
      exp_pc += 8;
      guard++;
    end
    set_in(1'b0, 1'b0, 2'd0, '0, '0, 2'd0);
    checks += 2;
    if (exp_pc !== 32'h60) begin failures++; $display("FAIL drain_total got=%h exp=60", exp_pc); end
    if (count !== 4'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", count); end
  endtask

  task automatic test_concurrent();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 1'b0, (k < 3) ? 2'd2 : 2'd1, {32'(k), $urandom}, {32'(k), $urandom}, 2'd0);
      tick();
    end
    checks += 2;
    if (count !== 4'd7) begin failures++; $display("FAIL conc_fill got=%0d exp=7", count); end
    if (push_ready !== 1'b0) begin failures++; $display("FAIL conc_ready7 got=%0b exp=0", push_ready); end
    set_in(1'b0, 1'b0, 2'd2, 64'h1111, 64'h2222, 2'd2);
    tick();
    checks += 2;
    if (count !== 4'd5) begin failures++; $display("FAIL conc_count got=%0d exp=5", count); end
    if (push_ready !== 1'b1) begin failures++; $display("FAIL conc_ready5 got=%0b exp=1", push_ready); end
    set_in(1'b0, 1'b0, 2'd2, 64'h3333, 64'h4444, 2'd0);
    tick();
    set_in(1'b0, 1'b0, 2'd0, '0, '0, 2'd0);
    checks += 2;
    if (count !== 4'd7) begin failures++; $display("FAIL conc_refill got=%0d exp=7", count); end
    if (out_data_a !== model[0]) begin failures++; $display("FAIL conc_head got=%h exp=%h", out_data_a, model[0]); end
  endtask

  task automatic test_overpop();
    do_reset();
    set_in(1'b0, 1'b0, 2'd1, 64'h00002000_CAFE0000, '0, 2'd0);
    tick();
    checks++;
    if (count !== 4'd1) begin failures++; $display("FAIL overpop_pre got=%0d exp=1", count); end
    set_in(1'b0, 1'b0, 2'd0, '0, '0, 2'd2);
    tick();
    set_in(1'b0, 1'b0, 2'd0, '0, '0, 2'd0);
    checks += 5;
    if (count !== 4'd0) begin failures++; $display("FAIL overpop_count got=%0d exp=0", count); end
    if (out_valid_a !== 1'b0) begin failures++; $display("FAIL overpop_va got=%0b exp=0", out_valid_a); end
    if (out_valid_b !== 1'b0) begin failures++; $display("FAIL overpop_vb got=%0b exp=0", out_valid_b); end
    if (out_data_a !== '0) begin failures++; $display("FAIL overpop_da got=%h exp=0", out_data_a); end
    if (out_data_b !== '0) begin failures++; $display("FAIL overpop_db got=%h exp=0", out_data_b); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      set_in(1'b0, 1'b0, 2'd2, {32'(k), $urandom}, {32'(k), $urandom}, 2'd0);
      tick();
    end
    set_in(1'b0, 1'b1, 2'd2, 64'h5555, 64'h6666, 2'd1);
    tick();
    checks += 3;
    if (count !== 4'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    if (out_valid_a !== 1'b0) begin failures++; $display("FAIL flush_va got=%0b exp=0", out_valid_a); end
    if (push_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%0b exp=1", push_ready); end
    set_in(1'b0, 1'b0, 2'd1, 64'h00003000_F00D0000, '0, 2'd0);
    tick();
    set_in(1'b0, 1'b0, 2'd0, '0, '0, 2'd0);
    checks += 2;
    if (out_data_a !== 64'h00003000_F00D0000) begin failures++; $display("FAIL flush_push got=%h exp=00003000f00d0000", out_data_a); end
    if (count !== 4'd1) begin failures++; $display("FAIL flush_push_count got=%0d exp=1", count); end
  endtask

  task automatic test_random();
    logic          e_va, e_vb, e_rdy;
    logic [EW-1:0] e_da, e_db;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      e_va  = (model.size() >= 1);
      e_vb  = (model.size() >= 2);
      e_da  = e_va ? model[0] : '0;
      e_db  = e_vb ? model[1] : '0;
      e_rdy = (DEPTH - model.size()) >= 2;
      checks += 6;
      if (count !== 4'(model.size())) begin failures++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, count, model.size()); end
      if (out_valid_a !== e_va) begin failures++; $display("FAIL rnd_va i=%0d got=%0b exp=%0b", i, out_valid_a, e_va); end
      if (out_valid_b !== e_vb) begin failures++; $display("FAIL rnd_vb i=%0d got=%0b exp=%0b", i, out_valid_b, e_vb); end
      if (out_data_a !== e_da) begin failures++; $display("FAIL rnd_da i=%0d got=%h exp=%h", i, out_data_a, e_da); end
      if (out_data_b !== e_db) begin failures++; $display("FAIL rnd_db i=%0d got=%h exp=%h", i, out_data_b, e_db); end
      if (push_ready !== e_rdy) begin failures++; $display("FAIL rnd_ready i=%0d got=%0b exp=%0b", i, push_ready, e_rdy); end
      set_in(($urandom_range(0, 63) == 0), ($urandom_range(0, 23) == 0),
             2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
             ((i / 50) % 2 == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3)));
      tick();
    end
    set_in(1'b0, 1'b0, 2'd0, '0, '0, 2'd0);
  endtask

  initial begin
    set_in(1'b1, 1'b0, 2'd0, '0, '0, 2'd0);
    @(negedge clk);
    test_reset();
    test_basic();
    test_fill();
    test_wrap();
    test_concurrent();
    test_overpop();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
